stack_unit: RTL and testbench

Hardware stack that services the control unit's push/pop requests. It holds the stack pointer and a private synchronous RAM, and accepts single-cycle push or pop pulses. Each accepted request completes with exactly one push_done or pop_done pulse; a pop also returns its data on pop_out. The block sits beside the ALU on the control unit's datapath and is the responder end of the CU push/pop handshake.

---
 rtl/stack_pkg.sv | 25 ++
 rtl/stack_if.sv | 27 ++
 rtl/stack_ram.sv | 23 ++
 rtl/stack_unit.sv | 129 ++++++++++++
 tb/tb_stack_unit.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/stack_pkg.sv
// Shared types and sizing helpers for the hardware stack.
package stack_pkg;

    localparam int unsigned DEFAULT_DEPTH  = 64;
    localparam int unsigned DEFAULT_DATA_W = 16;
    localparam int unsigned SP_W           = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PUSH    = 2'd1,
        POP     = 2'd2,
        POP_RET = 2'd3
    } state_t;

    // Ceiling log2, used to size the RAM address.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned w;
        w = 0;
        while ((32'd1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/stack_if.sv
// Push/pop handshake between the control unit (master) and the stack (slave).
interface stack_if #(
    parameter int unsigned DATA_W = 16
);
    logic              push_req;
    logic              pop_req;
    logic [DATA_W-1:0] push_data;
    logic [DATA_W-1:0] pop_out;
    logic              push_done;
    logic              pop_done;
    logic              busy;
    logic [15:0]       sp;
    logic              full;
    logic              empty;
    logic              overflow;
    logic              underflow;

    modport master (
        output push_req, pop_req, push_data,
        input  pop_out, push_done, pop_done, busy, sp, full, empty, overflow, underflow
    );

    modport slave (
        input  push_req, pop_req, push_data,
        output pop_out, push_done, pop_done, busy, sp, full, empty, overflow, underflow
    );
endinterface

// File: rtl/stack_ram.sv
// Single-port synchronous RAM with registered read data; contents are not reset.
module stack_ram #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned DEPTH  = 64,
    parameter int unsigned AW     = 6
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/stack_unit.sv
// Full-descending hardware stack: sp register, guarded push/pop FSM and private RAM.
module stack_unit
    import stack_pkg::*;
#(
    parameter int unsigned DATA_W = DEFAULT_DATA_W,
    parameter int unsigned DEPTH  = DEFAULT_DEPTH
) (
    input  logic   clk,
    input  logic   rst_b,
    stack_if.slave bus
);

    localparam int unsigned AW  = clog2(DEPTH);
    // sp spans 0..DEPTH inclusive, so it needs one bit beyond the RAM address.
    localparam int unsigned SPW = AW + 1;

    state_t            state_q;
    state_t            state_d;
    logic [SPW-1:0]    sp_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] pop_out_q;
    logic              push_done_q;
    logic              pop_done_q;
    logic              overflow_q;
    logic              underflow_q;

    logic              full_c;
    logic              empty_c;
    logic              ram_we;
    logic [AW-1:0]     ram_addr;
    logic [DATA_W-1:0] ram_rdata;

    assign full_c  = (sp_q == '0);
    assign empty_c = (sp_q == SPW'(DEPTH));

    // State register.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and RAM control; push has priority over a simultaneous pop.
    always_comb begin
        state_d  = state_q;
        ram_we   = 1'b0;
        ram_addr = AW'(sp_q);
        unique case (state_q)
            IDLE: begin
                if (bus.push_req) begin
                    state_d = PUSH;
                end else if (bus.pop_req) begin
                    state_d = POP;
                end
            end
            PUSH: begin
                state_d  = IDLE;
                ram_we   = !full_c;
                ram_addr = AW'(sp_q - SPW'(1));
            end
            POP: begin
                state_d = POP_RET;
            end
            POP_RET: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Stack pointer, captured push data and registered completion outputs.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            sp_q        <= SPW'(DEPTH);
            wdata_q     <= '0;
            pop_out_q   <= '0;
            push_done_q <= 1'b0;
            pop_done_q  <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            push_done_q <= (state_q == PUSH);
            overflow_q  <= (state_q == PUSH) && full_c;
            pop_done_q  <= (state_q == POP_RET);
            underflow_q <= (state_q == POP_RET) && empty_c;
            if ((state_q == IDLE) && bus.push_req) begin
                wdata_q <= bus.push_data;
            end
            if ((state_q == PUSH) && !full_c) begin
                sp_q <= sp_q - SPW'(1);
            end
            if (state_q == POP_RET) begin
                if (empty_c) begin
                    pop_out_q <= '0;
                end else begin
                    pop_out_q <= ram_rdata;
                    sp_q      <= sp_q + SPW'(1);
                end
            end
        end
    end

    stack_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (wdata_q),
        .rdata (ram_rdata)
    );

    assign bus.pop_out   = pop_out_q;
    assign bus.push_done = push_done_q;
    assign bus.pop_done  = pop_done_q;
    assign bus.overflow  = overflow_q;
    assign bus.underflow = underflow_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.sp        = 16'(sp_q);
    assign bus.full      = full_c;
    assign bus.empty     = empty_c;

endmodule

// File: tb/tb_stack_unit.sv
// Scoreboard bench for stack_unit: a reference stack predicts each completion.
module tb_stack_unit;

    localparam int unsigned DEPTH = 64;

    typedef struct {
        logic [15:0] data;
        logic        flag;
    } exp_t;

    logic clk;
    logic rst_b;

    stack_if #(.DATA_W(16)) bus ();

    stack_unit #(
        .DATA_W (16),
        .DEPTH  (DEPTH)
    ) dut (
        .clk   (clk),
        .rst_b (rst_b),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] mdl_mem [DEPTH];
    int          mdl_sp = DEPTH;
    exp_t        exp_pop[$];
    logic        exp_push[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
        end
    endtask

    // Completion monitor: every done pulse must match the oldest prediction.
    always @(negedge clk) begin
        if (rst_b) begin
            if (bus.push_done) begin
                if (exp_push.size() == 0) begin
                    check_eq("push_spurious", 32'(bus.push_done), 32'd0);
                end else begin
                    check_eq("overflow", 32'(bus.overflow), 32'(exp_push.pop_front()));
                end
            end
            if (bus.pop_done) begin
                if (exp_pop.size() == 0) begin
                    check_eq("pop_spurious", 32'(bus.pop_done), 32'd0);
                end else begin
                    exp_t e;
                    e = exp_pop.pop_front();
                    check_eq("pop_out", 32'(bus.pop_out), 32'(e.data));
                    check_eq("underflow", 32'(bus.underflow), 32'(e.flag));
                end
            end
        end
    end

    task automatic wait_push_done();
        int lat;
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            #1;
        end while (!bus.push_done && lat < 10);
        check_eq("push_lat", 32'(lat), 32'd1);
    endtask

    task automatic model_push(input logic [15:0] d);
        if (mdl_sp == 0) begin
            exp_push.push_back(1'b1);
        end else begin
            mdl_sp--;
            mdl_mem[mdl_sp] = d;
            exp_push.push_back(1'b0);
        end
    endtask

    task automatic do_push(input logic [15:0] d);
        @(negedge clk);
        bus.push_req  = 1'b1;
        bus.push_data = d;
        model_push(d);
        @(posedge clk);
        #1 bus.push_req = 1'b0;
        wait_push_done();
    endtask

    // Pop; with poke set, a push pulse is fired during the busy window and must be ignored.
    task automatic do_pop(input bit poke);
        exp_t e;
        int   lat;
        @(negedge clk);
        bus.pop_req = 1'b1;
        if (mdl_sp == DEPTH) begin
            e.data = 16'h0000;
            e.flag = 1'b1;
        end else begin
            e.data = mdl_mem[mdl_sp];
            e.flag = 1'b0;
            mdl_sp++;
        end
        exp_pop.push_back(e);
        @(posedge clk);
        #1 bus.pop_req = 1'b0;
        lat = 0;
        if (poke) begin
            check_eq("busy_pop", 32'(bus.busy), 32'd1);
            bus.push_req  = 1'b1;
            bus.push_data = 16'hBEEF;
            @(posedge clk);
            #1 bus.push_req = 1'b0;
            lat = 1;
        end
        do begin
            @(posedge clk);
            lat++;
            #1;
        end while (!bus.pop_done && lat < 10);
        check_eq("pop_lat", 32'(lat), 32'd2);
    endtask

    task automatic check_sp(input string tag);
        check_eq(tag, 32'(bus.sp), 32'(mdl_sp));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] d;
        bus.push_req  = 1'b0;
        bus.pop_req   = 1'b0;
        bus.push_data = '0;
        rst_b = 1'b0;
        repeat (3) @(negedge clk);
        rst_b = 1'b1;

        // Reset and idle.
        repeat (10) begin
            @(negedge clk);
            check_eq("rst_sp", 32'(bus.sp), 32'd64);
            check_eq("rst_flags", {26'd0, bus.empty, bus.full, bus.push_done, bus.pop_done,
                                   bus.overflow, bus.underflow}, 32'h20);
            check_eq("rst_busy_popout", {15'd0, bus.busy, bus.pop_out}, 32'd0);
        end

        // Single push/pop.
        do_push(16'h1234);
        check_eq("sp_after_push", 32'(bus.sp), 32'd63);
        do_pop(1'b0);
        check_eq("sp_after_pop", 32'(bus.sp), 32'd64);

        // LIFO order.
        do_push(16'hA001);
        do_push(16'hA002);
        do_push(16'hA003);
        repeat (3) do_pop(1'b0);
        check_sp("sp_lifo");

        // Fill, overflow, drain.
        for (int i = 0; i < DEPTH; i++) begin
            d = 16'($urandom);
            do_push(d);
        end
        @(negedge clk);
        check_eq("full_flag", 32'(bus.full), 32'd1);
        check_eq("sp_full", 32'(bus.sp), 32'd0);
        do_push(16'hFFFF);
        check_eq("sp_overflow", 32'(bus.sp), 32'd0);
        for (int i = 0; i < DEPTH; i++) begin
            do_pop(1'b0);
        end
        check_sp("sp_drained");

        // Underflow.
        do_pop(1'b0);
        check_eq("sp_underflow", 32'(bus.sp), 32'd64);
        check_eq("empty_flag", 32'(bus.empty), 32'd1);

        // Simultaneous push and pop: push wins.
        @(negedge clk);
        bus.push_req  = 1'b1;
        bus.pop_req   = 1'b1;
        bus.push_data = 16'h0042;
        model_push(16'h0042);
        @(posedge clk);
        #1;
        bus.push_req = 1'b0;
        bus.pop_req  = 1'b0;
        wait_push_done();
        repeat (4) @(negedge clk);
        check_eq("sp_both", 32'(bus.sp), 32'd63);
        do_pop(1'b0);

        // Push pulse while busy is ignored.
        do_push(16'h0077);
        do_pop(1'b1);
        repeat (4) @(negedge clk);
        check_eq("sp_busy_ignored", 32'(bus.sp), 32'd64);

        // Reset during POP aborts without a done pulse.
        do_push(16'h0099);
        @(negedge clk);
        bus.pop_req = 1'b1;
        @(posedge clk);
        #1 bus.pop_req = 1'b0;
        @(negedge clk);
        rst_b = 1'b0;
        mdl_sp = DEPTH;
        repeat (2) @(negedge clk);
        rst_b = 1'b1;
        repeat (6) @(negedge clk);
        check_eq("sp_after_abort", 32'(bus.sp), 32'd64);
        check_eq("busy_after_abort", 32'(bus.busy), 32'd0);
        check_eq("popout_after_abort", 32'(bus.pop_out), 32'd0);

        check_eq("exp_pop_drained", 32'(exp_pop.size()), 32'd0);
        check_eq("exp_push_drained", 32'(exp_push.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
